// File: rtl/radar_pkg.sv
// Shared definitions for the radar ARP/ACP/TRIG generator and measurement path.
// State encoding, minimum legal settings and the configuration validity check.
package radar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [63:0] ARP_US_MIN  = 64'd2;
    localparam logic [63:0] TRIG_US_MIN = 64'd1;

    // Arguments are zero-extended to 64 bits so any DATA_WIDTH up to 64 can use it.
    function automatic logic cfg_valid(
        input logic [63:0] arp_us,
        input logic [63:0] acp_cnt,
        input logic [63:0] trig_us
    );
        return (arp_us >= ARP_US_MIN) &&
               (acp_cnt != 64'd0) &&
               (acp_cnt <= arp_us) &&
               (trig_us >= TRIG_US_MIN);
    endfunction

endpackage

// File: rtl/radar_pulse_stretch.sv
// Stretches a single-cycle strobe into a level lasting PULSE_US microsecond ticks.
// A strobe while the level is high reloads the count, keeping the level continuous.
module radar_pulse_stretch #(
    parameter int PULSE_US = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic usec_pe_i,
    input  logic clr_i,
    input  logic strobe_i,
    output logic level_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (strobe_i) begin
            cnt_d = 8'(PULSE_US);
        end else if (usec_pe_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign level_o = (cnt_q != 8'd0);

endmodule

// File: rtl/radar_signal_gen.sv
// Radar timing generator: ARP, ACP and TRIG strobes plus stretched levels,
// driven from the shared microsecond strobe with a Bresenham ACP accumulator.
module radar_signal_gen
    import radar_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PULSE_US   = 2
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESET,
    input  logic                  USEC_PE,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] CFG_ARP_US,
    input  logic [DATA_WIDTH-1:0] CFG_ACP_CNT,
    input  logic [DATA_WIDTH-1:0] CFG_TRIG_US,
    output logic                  RADAR_ARP_PE,
    output logic                  RADAR_ACP_PE,
    output logic                  RADAR_TRIG_PE,
    output logic                  RADAR_ARP,
    output logic                  RADAR_ACP,
    output logic                  RADAR_TRIG,
    output logic                  RUNNING,
    output logic                  CFG_ERR,
    output logic [DATA_WIDTH-1:0] ROTATION_CNT
);

    localparam int DW = DATA_WIDTH;

    state_e        state_q, state_d;
    logic [DW-1:0] arp_sh_q, arp_sh_d;
    logic [DW-1:0] acp_sh_q, acp_sh_d;
    logic [DW-1:0] trig_sh_q, trig_sh_d;
    logic [DW-1:0] arp_cnt_q, arp_cnt_d;
    logic [DW-1:0] trig_cnt_q, trig_cnt_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] rot_q, rot_d;
    logic          arp_pe_q, arp_pe_d;
    logic          acp_pe_q, acp_pe_d;
    logic          trig_pe_q, trig_pe_d;
    logic          err_q, err_d;

    logic          cfg_ok;
    logic          arp_hit;
    logic [DW-1:0] eff_arp;
    logic [DW-1:0] eff_trig;
    logic [DW:0]   acc_sum;
    logic [DW:0]   arp_inc;
    logic [DW:0]   trig_inc;
    logic          run_active;

    assign cfg_ok = cfg_valid(64'(CFG_ARP_US), 64'(CFG_ACP_CNT),
                              64'(CFG_TRIG_US));

    always_comb begin
        state_d    = state_q;
        arp_sh_d   = arp_sh_q;
        acp_sh_d   = acp_sh_q;
        trig_sh_d  = trig_sh_q;
        arp_cnt_d  = arp_cnt_q;
        trig_cnt_d = trig_cnt_q;
        acc_d      = acc_q;
        rot_d      = rot_q;
        err_d      = err_q;
        arp_pe_d   = 1'b0;
        acp_pe_d   = 1'b0;
        trig_pe_d  = 1'b0;
        arp_hit    = (arp_cnt_q == '0);
        eff_arp    = arp_sh_q;
        eff_trig   = trig_sh_q;
        acc_sum    = {1'b0, acc_q} + {1'b0, acp_sh_q};
        arp_inc    = {1'b0, arp_cnt_q} + (DW+1)'(1);
        trig_inc   = {1'b0, trig_cnt_q} + (DW+1)'(1);

        unique case (state_q)
            IDLE: begin
                err_d = ENABLE && !cfg_ok;
                if (ENABLE && cfg_ok) begin
                    state_d    = RUN;
                    arp_sh_d   = CFG_ARP_US;
                    acp_sh_d   = CFG_ACP_CNT;
                    trig_sh_d  = CFG_TRIG_US;
                    arp_cnt_d  = '0;
                    trig_cnt_d = '0;
                    acc_d      = '0;
                    rot_d      = '0;
                end
            end
            RUN: begin
                if (!ENABLE) begin
                    state_d    = IDLE;
                    arp_cnt_d  = '0;
                    trig_cnt_d = '0;
                    acc_d      = '0;
                    rot_d      = '0;
                    err_d      = 1'b0;
                end else if (USEC_PE) begin
                    // A reload on the ARP tick already governs this tick's period math.
                    if (arp_hit) begin
                        arp_pe_d = 1'b1;
                        acp_pe_d = 1'b1;
                        acc_d    = '0;
                        rot_d    = rot_q + DW'(1);
                        if (cfg_ok) begin
                            arp_sh_d  = CFG_ARP_US;
                            acp_sh_d  = CFG_ACP_CNT;
                            trig_sh_d = CFG_TRIG_US;
                            eff_arp   = CFG_ARP_US;
                            eff_trig  = CFG_TRIG_US;
                            err_d     = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (acc_sum >= {1'b0, arp_sh_q}) begin
                        acp_pe_d = 1'b1;
                        acc_d    = DW'(acc_sum - {1'b0, arp_sh_q});
                    end else begin
                        acc_d = acc_sum[DW-1:0];
                    end
                    arp_cnt_d = (arp_inc >= {1'b0, eff_arp}) ?
                                '0 : arp_inc[DW-1:0];
                    trig_pe_d  = (trig_cnt_q == '0);
                    trig_cnt_d = (trig_inc >= {1'b0, eff_trig}) ?
                                 '0 : trig_inc[DW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q    <= IDLE;
            arp_sh_q   <= '0;
            acp_sh_q   <= '0;
            trig_sh_q  <= '0;
            arp_cnt_q  <= '0;
            trig_cnt_q <= '0;
            acc_q      <= '0;
            rot_q      <= '0;
            err_q      <= 1'b0;
            arp_pe_q   <= 1'b0;
            acp_pe_q   <= 1'b0;
            trig_pe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            arp_sh_q   <= arp_sh_d;
            acp_sh_q   <= acp_sh_d;
            trig_sh_q  <= trig_sh_d;
            arp_cnt_q  <= arp_cnt_d;
            trig_cnt_q <= trig_cnt_d;
            acc_q      <= acc_d;
            rot_q      <= rot_d;
            err_q      <= err_d;
            arp_pe_q   <= arp_pe_d;
            acp_pe_q   <= acp_pe_d;
            trig_pe_q  <= trig_pe_d;
        end
    end

    assign run_active = (state_q == RUN) && ENABLE;

    radar_pulse_stretch #(.PULSE_US(PULSE_US)) u_arp_lvl (
        .clk_i     (S_AXIS_ACLK),
        .rst_i     (S_AXIS_ARESET),
        .usec_pe_i (USEC_PE),
        .clr_i     (!run_active),
        .strobe_i  (arp_pe_d),
        .level_o   (RADAR_ARP)
    );

    radar_pulse_stretch #(.PULSE_US(PULSE_US)) u_acp_lvl (
        .clk_i     (S_AXIS_ACLK),
        .rst_i     (S_AXIS_ARESET),
        .usec_pe_i (USEC_PE),
        .clr_i     (!run_active),
        .strobe_i  (acp_pe_d),
        .level_o   (RADAR_ACP)
    );

    radar_pulse_stretch #(.PULSE_US(PULSE_US)) u_trig_lvl (
        .clk_i     (S_AXIS_ACLK),
        .rst_i     (S_AXIS_ARESET),
        .usec_pe_i (USEC_PE),
        .clr_i     (!run_active),
        .strobe_i  (trig_pe_d),
        .level_o   (RADAR_TRIG)
    );

    assign RADAR_ARP_PE  = arp_pe_q;
    assign RADAR_ACP_PE  = acp_pe_q;
    assign RADAR_TRIG_PE = trig_pe_q;
    assign RUNNING       = (state_q == RUN);
    assign CFG_ERR       = err_q;
    assign ROTATION_CNT  = rot_q;

endmodule

// File: tb/tb_radar_signal_gen.sv
// Directed bench for radar_signal_gen: rotation timing, ACP spread, boundaries,
// reconfiguration, invalid config, disable and asynchronous reset.
module tb_radar_signal_gen;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          usec = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] arp_us = '0;
    logic [DW-1:0] acp_cnt = '0;
    logic [DW-1:0] trig_us = '0;

    logic          arp_pe, acp_pe, trig_pe;
    logic          arp_lv, acp_lv, trig_lv;
    logic          running, cfg_err;
    logic [DW-1:0] rot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radar_signal_gen #(.DATA_WIDTH(DW), .PULSE_US(2)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .USEC_PE       (usec),
        .ENABLE        (en),
        .CFG_ARP_US    (arp_us),
        .CFG_ACP_CNT   (acp_cnt),
        .CFG_TRIG_US   (trig_us),
        .RADAR_ARP_PE  (arp_pe),
        .RADAR_ACP_PE  (acp_pe),
        .RADAR_TRIG_PE (trig_pe),
        .RADAR_ARP     (arp_lv),
        .RADAR_ACP     (acp_lv),
        .RADAR_TRIG    (trig_lv),
        .RUNNING       (running),
        .CFG_ERR       (cfg_err),
        .ROTATION_CNT  (rot)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick: USEC_PE high for one cycle, then one idle cycle.
    task automatic tick(output logic [2:0] pe, output logic [1:0] lv1,
                        output logic [1:0] lv2);
        usec = 1'b1;
        @(negedge clk);
        usec = 1'b0;
        pe  = {arp_pe, acp_pe, trig_pe};
        lv1 = {acp_lv, trig_lv};
        @(negedge clk);
        lv2 = {acp_lv, trig_lv};
    endtask

    function automatic logic [7:0] flags();
        return {arp_pe, acp_pe, trig_pe, arp_lv, acp_lv, trig_lv,
                running, cfg_err};
    endfunction

    initial begin
        logic [2:0] pe;
        logic [1:0] l1, l2;
        logic [2:0] e;
        logic       a, c, t;

        @(negedge clk);
        chk("reset_flags", 64'(flags()), 64'h0);
        chk("reset_rot", 64'(rot), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        arp_us = 1; acp_cnt = 1; trig_us = 1; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(pe, l1, l2);
            chk("invalid_pe", 64'(pe), 64'h0);
            chk("invalid_running", 64'(running), 64'h0);
            chk("invalid_err", 64'(cfg_err), 64'h1);
        end
        en = 1'b0;
        @(negedge clk);
        chk("invalid_err_clear", 64'(cfg_err), 64'h0);

        arp_us = 1000; acp_cnt = 4; trig_us = 250; en = 1'b1;
        @(negedge clk);
        chk("basic_running", 64'(running), 64'h1);
        for (int k = 0; k < 5000; k++) begin
            tick(pe, l1, l2);
            e = {k % 1000 == 0, k % 250 == 0, k % 250 == 0};
            chk("basic_pe", 64'(pe), 64'(e));
        end
        chk("basic_rot", 64'(rot), 64'd5);

        en = 1'b0;
        @(negedge clk);
        arp_us = 10; acp_cnt = 3; trig_us = 5; en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            tick(pe, l1, l2);
            a = (k % 10 == 0);
            c = (k % 10 == 0) || (k % 10 == 4) || (k % 10 == 7);
            t = (k % 5 == 0);
            chk("uneven_pe", 64'(pe), 64'({a, c, t}));
        end
        chk("uneven_rot", 64'(rot), 64'd3);

        usec = 1'b1;
        @(negedge clk);
        usec = 1'b0;
        chk("predis_pe", 64'({arp_pe, acp_pe, trig_pe, acp_lv}), 64'hF);
        en = 1'b0;
        @(negedge clk);
        chk("disable_flags", 64'(flags()), 64'h0);
        chk("disable_rot", 64'(rot), 64'h0);
        en = 1'b1;
        @(negedge clk);
        tick(pe, l1, l2);
        chk("reenable_pe", 64'(pe), 64'h7);
        chk("reenable_rot", 64'(rot), 64'd1);

        en = 1'b0;
        @(negedge clk);
        arp_us = 8; acp_cnt = 8; trig_us = 1; en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            tick(pe, l1, l2);
            chk("bound_pe", 64'(pe), 64'({k % 8 == 0, 1'b1, 1'b1}));
            chk("bound_lv_tick", 64'(l1), 64'h3);
            chk("bound_lv_idle", 64'(l2), 64'h3);
        end

        en = 1'b0;
        @(negedge clk);
        arp_us = 1000; acp_cnt = 4; trig_us = 250; en = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 2500; k++) begin
            if (k == 300) arp_us = 500;
            if (k == 1600) acp_cnt = 0;
            tick(pe, l1, l2);
            a = (k < 1000) ? (k == 0) : ((k - 1000) % 500 == 0);
            c = (k < 1000) ? (k % 250 == 0) : ((k - 1000) % 125 == 0);
            t = (k % 250 == 0);
            chk("reconf_pe", 64'(pe), 64'({a, c, t}));
            if (k == 1999) chk("reconf_err_before", 64'(cfg_err), 64'h0);
            if (k == 2000) chk("reconf_err_after", 64'(cfg_err), 64'h1);
        end
        chk("reconf_rot", 64'(rot), 64'd5);
        chk("reconf_err_held", 64'(cfg_err), 64'h1);

        chk("prereset_running", 64'(running), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_flags", 64'(flags()), 64'h0);
        chk("async_reset_rot", 64'(rot), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
